// File: rtl/led_sequence_scheduler.sv
`default_nettype none
// =============================================================================
// led_sequence_scheduler
// Queued 4-LED pattern sequencer: 4-deep command FIFO, prescaled dwell timing.
// Revision: 1.0
// =============================================================================

module led_sequence_scheduler #(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       abort,
  input  logic [7:0] max,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_steps,
  output logic [3:0] led,
  output logic       busy,
  output logic       done,
  output logic [2:0] fifo_count
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [1:0]    MODE_LEFT  = 2'd0;
  localparam logic [1:0]    MODE_RIGHT = 2'd1;
  localparam logic [1:0]    MODE_BLINK = 2'd2;
  localparam logic [3:0]    LED_IDLE   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    steps_q, steps_d;
  logic [7:0]    max_q, max_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [7:0]    step_q, step_d;
  logic [9:0]    mem_q [4];
  logic [9:0]    mem_d [4];
  logic [1:0]    wr_q, wr_d;
  logic [1:0]    rd_q, rd_d;
  logic [2:0]    count_q, count_d;

  logic          w_push;
  logic          w_pop;
  logic          w_tick;
  logic [7:0]    w_step_next;
  logic [9:0]    w_head;

  function automatic logic [3:0] advance_pattern(input logic [1:0] mode, input logic [3:0] p);
    case (mode)
      MODE_LEFT:  return {p[2:0], p[3]};
      MODE_RIGHT: return {p[0], p[3:1]};
      MODE_BLINK: return ~p;
      default:    return p;
    endcase
  endfunction

  assign cmd_ready   = !rst && (count_q != 3'd4) && !abort;
  assign w_push      = cmd_valid && cmd_ready;
  assign w_tick      = (presc_q == PRESC_LAST);
  assign w_step_next = step_q + 8'd1;
  assign w_head      = mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    steps_d = steps_q;
    max_d   = max_q;
    presc_d = presc_q;
    dwell_d = dwell_q;
    step_d  = step_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    w_pop   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      led_d   = LED_IDLE;
      wr_d    = 2'd0;
      rd_d    = 2'd0;
      count_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          led_d = LED_IDLE;
          if (count_q != 3'd0 && !pause) state_d = LOAD;
        end
        LOAD: begin
          w_pop   = 1'b1;
          mode_d  = w_head[9:8];
          steps_d = w_head[7:0];
          max_d   = max;
          presc_d = '0;
          dwell_d = 8'd0;
          step_d  = 8'd0;
          case (w_head[9:8])
            MODE_LEFT:  led_d = 4'b0001;
            MODE_RIGHT: led_d = 4'b1000;
            default:    led_d = 4'b1111;
          endcase
          state_d = RUN;
        end
        RUN: begin
          if (!pause) begin
            presc_d = w_tick ? '0 : presc_q + 1'b1;
            if (w_tick) begin
              if (dwell_q == max_q) begin
                dwell_d = 8'd0;
                step_d  = w_step_next;
                // The final advance ends the command; its rotated pattern is discarded.
                if (steps_q != 8'd0 && w_step_next == steps_q) begin
                  done_d = 1'b1;
                  if (count_q != 3'd0) begin
                    state_d = LOAD;
                  end else begin
                    state_d = IDLE;
                    led_d   = LED_IDLE;
                  end
                end else begin
                  led_d = advance_pattern(mode_q, led_q);
                end
              end else begin
                dwell_d = dwell_q + 8'd1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (w_push) begin
        mem_d[wr_q] = {cmd_mode, cmd_steps};
        wr_d        = wr_q + 2'd1;
      end
      if (w_pop) rd_d = rd_q + 2'd1;
      count_d = count_q + 3'(w_push) - 3'(w_pop);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= LED_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 2'd0;
      steps_q <= 8'd0;
      max_q   <= 8'd0;
      presc_q <= '0;
      dwell_q <= 8'd0;
      step_q  <= 8'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 10'd0;
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      steps_q <= steps_d;
      max_q   <= max_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign led        = led_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_count = count_q;

endmodule

`default_nettype wire
